// File: rtl/boids_pkg.sv
// Shared constants, FSM state type and pixel address helper for the boid
// frame-buffer scheduler.
package boids_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int FB_ADDR_W = 19;

    localparam logic [7:0] BG_COLOR   = 8'd31;
    localparam logic [7:0] BOID_COLOR = 8'd42;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ERASE,
        S_DRAW,
        S_NEXT,
        S_DONE
    } state_t;

    // x + 640*y, with 640*y built as (y<<9)+(y<<7) at full address width
    function automatic logic [FB_ADDR_W-1:0] pix_addr(input logic [10:0] x,
                                                      input logic [9:0]  y);
        logic [FB_ADDR_W-1:0] xw;
        logic [FB_ADDR_W-1:0] yw;
        xw = FB_ADDR_W'(x);
        yw = FB_ADDR_W'(y);
        return (yw << 9) + (yw << 7) + xw;
    endfunction

endpackage

// File: rtl/boid_pos_store.sv
// Per-boid register file of last drawn positions {valid, x, y}; one combinational
// read port, one write port, synchronous clear on reset.
module boid_pos_store #(
    parameter int NUM_BOIDS = 16,
    parameter int IDX_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [9:0]       rd_x,
    output logic [8:0]       rd_y,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [9:0]       wr_x,
    input  logic [8:0]       wr_y
);

    logic       valid_q [NUM_BOIDS];
    logic [9:0] x_q     [NUM_BOIDS];
    logic [8:0] y_q     [NUM_BOIDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BOIDS; i++) begin
                valid_q[i] <= 1'b0;
                x_q[i]     <= '0;
                y_q[i]     <= '0;
            end
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            x_q[wr_idx]     <= wr_x;
            y_q[wr_idx]     <= wr_y;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_x     = x_q[rd_idx];
    assign rd_y     = y_q[rd_idx];

endmodule

// File: rtl/boid_fb_scheduler.sv
// Walks all boids each frame: fetch position, erase old pixel, draw new pixel,
// sharing the frame-buffer port with scan-out. Define BOID_FB_CROSS_EN for 5-pixel plus-shaped boids.
module boid_fb_scheduler
    import boids_pkg::*;
#(
    parameter int NUM_BOIDS = 16,
    parameter int IDX_W     = 4,
    parameter int ADDR_W    = 19,
    parameter int COLOR_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               screenEnd,
    input  logic               active,
    input  logic [ADDR_W-1:0]  scan_addr,
    output logic               pos_req,
    output logic [IDX_W-1:0]   pos_idx,
    input  logic               pos_valid,
    input  logic [9:0]         pos_x,
    input  logic [8:0]         pos_y,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic               fb_wen,
    output logic [COLOR_W-1:0] fb_wdata,
    output logic               busy,
    output logic               frame_done,
    output logic               overrun
);

    state_t     state, state_nx;
    logic [9:0] new_x;
    logic [8:0] new_y;
    logic       old_valid;
    logic [9:0] old_x;
    logic [8:0] old_y;

    logic [9:0]  bx;
    logic [8:0]  by;
    logic [10:0] dx, px;
    logic [9:0]  dy, py;
    logic        neg, sub_last, pix_ok, wr_pend;
    logic [ADDR_W-1:0] wr_addr;

`ifdef BOID_FB_CROSS_EN
    logic [2:0] sub;
`endif

    boid_pos_store #(.NUM_BOIDS(NUM_BOIDS), .IDX_W(IDX_W)) u_store (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (pos_idx),
        .rd_valid (old_valid),
        .rd_x     (old_x),
        .rd_y     (old_y),
        .wr_en    (state == S_NEXT),
        .wr_idx   (pos_idx),
        .wr_x     (new_x),
        .wr_y     (new_y)
    );

    // Pixel currently targeted by ERASE/DRAW, with its range check and address
    always_comb begin
        bx       = (state == S_ERASE) ? old_x : new_x;
        by       = (state == S_ERASE) ? old_y : new_y;
        dx       = '0;
        dy       = '0;
        neg      = 1'b0;
        sub_last = 1'b1;
`ifdef BOID_FB_CROSS_EN
        sub_last = (sub == 3'd4);
        case (sub)
            3'd1: begin dx = '1; neg = (bx == '0); end
            3'd2: dx = 11'd1;
            3'd3: begin dy = '1; neg = (by == '0); end
            3'd4: dy = 10'd1;
            default: ;
        endcase
`endif
        px      = {1'b0, bx} + dx;
        py      = {1'b0, by} + dy;
        pix_ok  = !neg && (px < 11'(SCREEN_W)) && (py < 10'(SCREEN_H))
                  && ((state == S_DRAW) || old_valid);
        wr_pend = ((state == S_ERASE) || (state == S_DRAW)) && pix_ok;
        wr_addr = ADDR_W'(pix_addr(px, py));
    end

    always_comb begin
        state_nx   = state;
        pos_req    = (state == S_FETCH);
        busy       = (state != S_IDLE);
        frame_done = (state == S_DONE);
        fb_wen     = wr_pend && !active;
        fb_addr    = fb_wen ? wr_addr : scan_addr;
        fb_wdata   = (state == S_DRAW) ? COLOR_W'(BOID_COLOR) : COLOR_W'(BG_COLOR);
        case (state)
            S_IDLE:  if (screenEnd) state_nx = S_FETCH;
            S_FETCH: if (pos_valid) state_nx = S_ERASE;
            S_ERASE: if (!active && sub_last) state_nx = S_DRAW;
            S_DRAW:  if (!active && sub_last) state_nx = S_NEXT;
            S_NEXT:  state_nx = (pos_idx == IDX_W'(NUM_BOIDS - 1)) ? S_DONE : S_FETCH;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            pos_idx <= '0;
            new_x   <= '0;
            new_y   <= '0;
            overrun <= 1'b0;
`ifdef BOID_FB_CROSS_EN
            sub     <= '0;
`endif
        end else begin
            state <= state_nx;
            if (screenEnd && (state != S_IDLE))
                overrun <= 1'b1;
            if ((state == S_IDLE) && screenEnd)
                pos_idx <= '0;
            if ((state == S_FETCH) && pos_valid) begin
                new_x <= pos_x;
                new_y <= pos_y;
            end
            if ((state == S_NEXT) && (pos_idx != IDX_W'(NUM_BOIDS - 1)))
                pos_idx <= pos_idx + IDX_W'(1);
`ifdef BOID_FB_CROSS_EN
            if (((state == S_ERASE) || (state == S_DRAW)) && !active)
                sub <= sub_last ? 3'd0 : sub + 3'd1;
`endif
        end
    end

endmodule

// File: tb/tb_boid_fb_scheduler.sv
// Scoreboard bench for boid_fb_scheduler with two boids: directed frames push
// expected RAM writes; a negedge monitor pops and compares every issued write.
module tb_boid_fb_scheduler;

    localparam int NB = 2;
    localparam int IW = 1;
    localparam int AW = 19;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          screenEnd = 1'b0;
    logic          active = 1'b0;
    logic [AW-1:0] scan_addr = '0;
    logic          pos_req;
    logic [IW-1:0] pos_idx;
    logic          pos_valid = 1'b1;
    logic [9:0]    pos_x;
    logic [8:0]    pos_y;
    logic [AW-1:0] fb_addr;
    logic          fb_wen;
    logic [CW-1:0] fb_wdata;
    logic          busy;
    logic          frame_done;
    logic          overrun;

    logic [9:0] x_tab [NB];
    logic [8:0] y_tab [NB];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [CW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  start_cyc = 0;

    assign pos_x = x_tab[pos_idx];
    assign pos_y = y_tab[pos_idx];

    always #5 clk = ~clk;

    boid_fb_scheduler #(.NUM_BOIDS(NB), .IDX_W(IW), .ADDR_W(AW), .COLOR_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .screenEnd  (screenEnd),
        .active     (active),
        .scan_addr  (scan_addr),
        .pos_req    (pos_req),
        .pos_idx    (pos_idx),
        .pos_valid  (pos_valid),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .fb_addr    (fb_addr),
        .fb_wen     (fb_wen),
        .fb_wdata   (fb_wdata),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    // Monitor: every issued write must match the head of the expected queue,
    // and while scan-out owns the port the scheduler must stay off it
    always @(negedge clk) begin
        if (fb_wen) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write addr=%0d data=%0d (none expected)",
                         fb_addr, fb_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (fb_addr !== e.addr || fb_wdata !== e.data) begin
                    errors++;
                    $display("[TB] FAIL write got addr=%0d data=%0d expected addr=%0d data=%0d",
                             fb_addr, fb_wdata, e.addr, e.data);
                end
            end
        end
        if (active && !reset) begin
            checks++;
            if (fb_wen !== 1'b0 || fb_addr !== scan_addr) begin
                errors++;
                $display("[TB] FAIL arbitration fb_wen=%0b fb_addr=%0d expected fb_wen=0 fb_addr=%0d",
                         fb_wen, fb_addr, scan_addr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic expectWrite(input int addr, input int data);
        wr_t w;
        w.addr = AW'(addr);
        w.data = CW'(data);
        exp_q.push_back(w);
    endtask

    // Load the two boid positions and issue a one-cycle screenEnd pulse
    task automatic applyStimulus(input int x0, input int y0, input int x1, input int y1);
        x_tab[0] = 10'(x0);
        y_tab[0] = 9'(y0);
        x_tab[1] = 10'(x1);
        y_tab[1] = 9'(y1);
        screenEnd = 1'b1;
        start_cyc = cyc;
        tick();
        screenEnd = 1'b0;
    endtask

    // Wait (bounded) for frame_done; optionally re-pulse screenEnd at a given offset
    task automatic waitDone(input string name, input int exp_cycles, input int over_at);
        while (!frame_done && (cyc - start_cyc) < 1000) begin
            screenEnd = ((cyc - start_cyc) == over_at);
            tick();
        end
        screenEnd = 1'b0;
        checkOutput({name, "_frame_done_seen"}, 32'(frame_done), 32'd1);
        checkOutput({name, "_latency"}, 32'(cyc - start_cyc), 32'(exp_cycles));
        tick();
        checkOutput({name, "_busy_after"}, 32'(busy), 32'd0);
        checkOutput({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        x_tab[0] = '0; y_tab[0] = '0;
        x_tab[1] = '0; y_tab[1] = '0;
        repeat (3) tick();
        checkOutput("rst_pos_req", 32'(pos_req), 32'd0);
        checkOutput("rst_pos_idx", 32'(pos_idx), 32'd0);
        checkOutput("rst_fb_wen", 32'(fb_wen), 32'd0);
        checkOutput("rst_fb_wdata", 32'(fb_wdata), 32'd31);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        tick();

        // First frame: draws only, no erases
        expectWrite(12810, 42);
        expectWrite(307199, 42);
        applyStimulus(10, 20, 639, 479);
        waitDone("f1", 9, -1);

        // boid0 moves one pixel; boid1 unchanged is erased then redrawn
        expectWrite(12810, 31);
        expectWrite(12811, 42);
        expectWrite(307199, 31);
        expectWrite(307199, 42);
        applyStimulus(11, 20, 639, 479);
        waitDone("f2", 9, -1);
        checkOutput("f2_overrun", 32'(overrun), 32'd0);

        // Scan-out holds the port for 50 cycles during boid0's DRAW
        expectWrite(12811, 31);
        expectWrite(12812, 42);
        expectWrite(307199, 31);
        expectWrite(307199, 42);
        applyStimulus(12, 20, 639, 479);
        tick();
        tick();
        active = 1'b1;
        for (int i = 0; i < 50; i++) begin
            scan_addr = AW'(1000 + 7 * i);
            tick();
        end
        active = 1'b0;
        #1;
        checkOutput("f3_release_wen", 32'(fb_wen), 32'd1);
        checkOutput("f3_release_addr", 32'(fb_addr), 32'd12812);
        waitDone("f3", 59, -1);

        // boid0 off-screen: erase old, skip draw; boid1 proceeds
        expectWrite(12812, 31);
        expectWrite(307199, 31);
        expectWrite(0, 42);
        applyStimulus(640, 5, 0, 0);
        waitDone("f4", 9, -1);

        // Out-of-range old entry is not erased; screenEnd while busy sets overrun
        expectWrite(641, 42);
        expectWrite(0, 31);
        expectWrite(0, 42);
        applyStimulus(1, 1, 0, 0);
        waitDone("f5", 9, 3);
        checkOutput("f5_overrun_set", 32'(overrun), 32'd1);
        repeat (3) tick();
        checkOutput("f5_overrun_sticky", 32'(overrun), 32'd1);

        // Reset during boid0's DRAW aborts the frame and clears history
        expectWrite(641, 31);
        expectWrite(3205, 42);
        applyStimulus(5, 5, 6, 6);
        tick();
        tick();
        reset = 1'b1;
        tick();
        checkOutput("f6_rst_wen", 32'(fb_wen), 32'd0);
        checkOutput("f6_rst_busy", 32'(busy), 32'd0);
        checkOutput("f6_rst_overrun", 32'(overrun), 32'd0);
        checkOutput("f6_queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        reset = 1'b0;
        tick();

        expectWrite(3205, 42);
        expectWrite(3846, 42);
        applyStimulus(5, 5, 6, 6);
        waitDone("f7", 9, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
